pipe_stage_reg: RTL and testbench
=================================

Name: pipe_stage_reg

Overview:
Parametrised pipeline stage register, successor to the fixed-width IF/ID flop pair. Carries a LANES-wide fetch bundle (instructions, base PC, lane-valid mask) between two stages using a valid/ready handshake instead of a raw enable. A one-entry skid buffer keeps full throughput with a registered in_ready, and a saturating back-pressure counter is included. Instantiated between IF and ID, and reusable at later stage boundaries.

Parameters:
DATA_W, 32, width of one instruction word and of the PC
LANES, 2, instructions per bundle (1..4)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
flush  input  1  synchronous squash of all held and incoming bundles
in_valid  input  1  upstream bundle valid
in_ready  output  1  stage can accept a bundle this cycle (registered)
in_instr  input  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
in_pc  input  DATA_W  PC of lane 0
in_mask  input  LANES  per-lane valid bits
out_valid  output  1  bundle presented downstream
out_ready  input  1  downstream accepts
out_instr  output  LANES*DATA_W  held instructions
out_pc  output  DATA_W  held PC
out_mask  output  LANES  held lane mask, forced 0 when out_valid=0
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Reset (rst=0, asynchronous): state EMPTY, out_valid=0, in_ready=1, all payload registers and stall_cnt = 0. A reset asserted mid-operation discards both entries immediately.
- Storage: main entry (drives outputs) plus one skid entry. Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
- States and transitions (flush=0):
  EMPTY: in -> FULL, main <= input. Otherwise stay.
  FULL: in & out -> FULL, main <= input. In only -> SKID, skid <= input. Out only -> EMPTY. Neither -> hold.
  SKID: in_ready=0. Out -> FULL, main <= skid. Otherwise hold.
- in_ready = (state != SKID). It is a register output and has no combinational path from out_ready.
- out_valid = (state != EMPTY).
- Latency: one cycle from acceptance to out_valid when EMPTY. Sustained throughput is 1 bundle/cycle while out_ready=1.
- Empty-mask bubbles: if in_valid=1 and in_mask=0, the bundle is accepted (consumes the handshake) but not stored, and state does not change because of it.
- flush=1 has highest priority:
  - Next state is EMPTY and both entries are invalidated.
  - Payload registers are cleared to 0.
  - Any input transferred in the same cycle is discarded.
  - in_ready=1 on the following cycle.
  - An output transfer in the flush cycle still counts as consumed downstream.
- Payload is held stable while out_valid=1 and out_ready=0.
- stall_cnt:
  - Increments on each cycle with out_valid=1 and out_ready=0.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst; flush does not clear it.
- out_pc carries the PC of lane 0 unchanged. Per-lane PCs are derived downstream.

Test Plan:
- Reset then stream: LANES=2; present bundles PC=0x100, 0x108, 0x110 (mask=2'b11) with out_ready=1 -> out_valid=1 from cycle 1; outputs show 0x100, 0x108, 0x110 on consecutive cycles; in_ready stays 1.
- Back-pressure and skid: hold out_ready=0 while sending 0x200 then 0x208 -> state SKID; in_ready=0 on the next cycle; out_pc stays 0x200; stall_cnt increments every cycle. Release out_ready -> 0x200 then 0x208 appear in order; nothing is lost or duplicated.
- Flush in SKID with a simultaneous input 0x300 -> next cycle out_valid=0, out_mask=0, out_pc=0, in_ready=1; 0x300 never appears at the output; stall_cnt is unchanged.
- Bubble: in_valid=1 with in_mask=2'b00 while EMPTY -> in_ready=1; out_valid remains 0 on the next cycle.
- Saturation: CNT_W=4; stall for 20 cycles -> stall_cnt reads 15 and holds.
- Async reset mid-stream: pull rst low between clock edges while in SKID -> out_valid=0 and stall_cnt=0 immediately (no clock edge required); in_ready=1.

Source files
------------

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with a valid/ready handshake and a one-entry skid
// buffer. Carries a LANES-wide fetch bundle (instructions, lane-0 PC, lane
// mask) between two stages. in_ready is a register, so the upstream path never
// sees out_ready combinationally. A saturating counter records cycles in which
// a bundle was offered downstream but not taken.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] in_instr,
  input  logic [DATA_W-1:0]       in_pc,
  input  logic [LANES-1:0]        in_mask,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES*DATA_W-1:0] out_instr,
  output logic [DATA_W-1:0]       out_pc,
  output logic [LANES-1:0]        out_mask,
  output logic [CNT_W-1:0]        stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } state_t;

  typedef struct packed {
    logic [LANES*DATA_W-1:0] instr;
    logic [DATA_W-1:0]       pc;
    logic [LANES-1:0]        mask;
  } bundle_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  bundle_t          main_q;
  bundle_t          skid_q;
  bundle_t          in_b;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [CNT_W-1:0] stall_q;
  logic             xfer_in;
  logic             xfer_out;

  assign in_b = '{instr: in_instr, pc: in_pc, mask: in_mask};

  // A bundle with no live lanes completes the handshake but is never stored.
  assign xfer_in  = in_valid & in_ready_q & (|in_mask);
  assign xfer_out = out_valid_q & out_ready;

  // Handshake FSM: main entry drives the outputs, skid entry absorbs the one
  // bundle that arrives in the cycle after downstream stalls.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: payload is reset along with control so a reset or flush never
      // leaves a stale bundle visible on the outputs.
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else if (flush) begin
      state       <= EMPTY;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register update in this
      // block based on the pre-edge values, independent of statement order.
      case (state)
        EMPTY: begin
          if (xfer_in) begin
            main_q      <= in_b;
            state       <= FULL;
            out_valid_q <= 1'b1;
          end
        end
        FULL: begin
          if (xfer_in && xfer_out) begin
            main_q <= in_b;
          end else if (xfer_in) begin
            skid_q     <= in_b;
            state      <= SKID;
            in_ready_q <= 1'b0;
          end else if (xfer_out) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
          end
        end
        SKID: begin
          if (xfer_out) begin
            main_q     <= skid_q;
            state      <= FULL;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state       <= EMPTY;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Saturating count of stalled cycles; only reset clears it, flush does not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (out_valid_q && !out_ready && stall_q != CNT_MAX) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_instr = main_q.instr;
  assign out_pc    = main_q.pc;
  assign out_mask  = out_valid_q ? main_q.mask : '0;
  assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Testbench for pipe_stage_reg. A predictor keeps the held bundles as a plain
// FIFO (at most two deep) and pushes every accepted bundle into a scoreboard
// queue; a monitor on the falling edge compares whatever the DUT presents.
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int LANES  = 2;
  localparam int CNT_W  = 4;
  localparam int CNT_SAT = (1 << CNT_W) - 1;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    flush;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_instr;
  logic [DATA_W-1:0]       in_pc;
  logic [LANES-1:0]        in_mask;
  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_instr;
  logic [DATA_W-1:0]       out_pc;
  logic [LANES-1:0]        out_mask;
  logic [CNT_W-1:0]        stall_cnt;

  pipe_stage_reg #(.DATA_W(DATA_W), .LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_mask   (in_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_mask  (out_mask),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LANES*DATA_W-1:0] instr;
    logic [DATA_W-1:0]       pc;
    logic [LANES-1:0]        mask;
  } exp_t;

  exp_t exp_q[$];
  int   occ;       // bundles held by the stage according to the model
  int   cnt;       // model stall counter
  bit   zero_pl;   // payload known to be cleared (after reset/flush, before next accept)
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    occ = 0;
    cnt = 0;
    exp_q.delete();
    zero_pl = 1'b1;
  endtask

  // Predictor: applies the transfer rules at each rising edge using the
  // inputs as they stood before the edge.
  always @(posedge clk) begin
    if (rst) begin
      bit xo;
      bit xi;
      xo = (occ > 0) && out_ready;
      xi = in_valid && (occ < 2) && (in_mask != '0);
      if (occ > 0 && !out_ready && cnt < CNT_SAT) cnt++;
      if (flush) begin
        occ = 0;
        exp_q.delete();
        zero_pl = 1'b1;
      end else begin
        if (xi) begin
          exp_q.push_back('{instr: in_instr, pc: in_pc, mask: in_mask});
          zero_pl = 1'b0;
        end
        occ = occ - int'(xo) + int'(xi);
      end
    end
  end

  // Monitor: compares handshake, counter and presented bundle mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      check("in_ready", 128'(in_ready), 128'(occ < 2));
      check("out_valid", 128'(out_valid), 128'(occ > 0));
      check("stall_cnt", 128'(stall_cnt), 128'(cnt));
      if (!out_valid) begin
        check("out_mask_idle", 128'(out_mask), 128'(0));
        if (zero_pl) begin
          check("out_pc_clr", 128'(out_pc), 128'(0));
          check("out_instr_clr", 128'(out_instr), 128'(0));
        end
      end else if (exp_q.size() == 0) begin
        check("unexpected_out", 128'(out_pc), 128'hFFFF_FFFF_FFFF);
      end else begin
        check("out_pc", 128'(out_pc), 128'(exp_q[0].pc));
        check("out_instr", 128'(out_instr), 128'(exp_q[0].instr));
        check("out_mask", 128'(out_mask), 128'(exp_q[0].mask));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the next edge.
  task automatic drive(input bit iv, input logic [DATA_W-1:0] pc, input logic [LANES-1:0] m,
                       input bit ordy, input bit fl);
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = {~pc, pc ^ 32'hDEAD_BEEF};
    in_mask   = m;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input int rdy_pct);
    in_valid  = ($urandom_range(0, 99) < 70);
    in_pc     = $urandom();
    in_instr  = {$urandom(), $urandom()};
    in_mask   = LANES'($urandom_range(0, 3));
    out_ready = ($urandom_range(0, 99) < rdy_pct);
    flush     = ($urandom_range(0, 39) == 0);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    in_valid = 1'b0; in_mask = '0; in_pc = '0; in_instr = '0;
    out_ready = 1'b0; flush = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_stall_cnt", 128'(stall_cnt), 128'(0));
    check("rst_out_pc", 128'(out_pc), 128'(0));
    rst = 1'b1;
  endtask

  initial begin
    apply_reset();

    // Streaming at full rate.
    drive(1, 32'h100, 2'b11, 1, 0);
    drive(1, 32'h108, 2'b11, 1, 0);
    drive(1, 32'h110, 2'b11, 1, 0);
    drive(0, 32'h0,   2'b00, 1, 0);
    drive(0, 32'h0,   2'b00, 1, 0);

    // Back-pressure into the skid entry, then release.
    drive(1, 32'h200, 2'b11, 0, 0);
    drive(1, 32'h208, 2'b11, 0, 0);
    repeat (3) drive(1, 32'h2F0, 2'b11, 0, 0);
    repeat (3) drive(0, 32'h0, 2'b00, 1, 0);

    // Flush while in SKID with an input offered in the same cycle.
    drive(1, 32'h240, 2'b01, 0, 0);
    drive(1, 32'h248, 2'b10, 0, 0);
    drive(1, 32'h300, 2'b11, 1, 1);
    drive(0, 32'h0,   2'b00, 1, 0);

    // Empty-mask bubble while EMPTY, then a real bundle behind it.
    drive(1, 32'h400, 2'b00, 1, 0);
    drive(1, 32'h408, 2'b01, 1, 0);
    drive(0, 32'h0,   2'b00, 1, 0);

    // Counter saturation.
    drive(1, 32'h500, 2'b11, 0, 0);
    repeat (20) drive(0, 32'h0, 2'b00, 0, 0);
    check("stall_sat", 128'(stall_cnt), 128'(CNT_SAT));
    repeat (2) drive(0, 32'h0, 2'b00, 1, 0);

    // Asynchronous reset between edges while in SKID.
    apply_reset();
    drive(1, 32'h600, 2'b11, 0, 0);
    drive(1, 32'h608, 2'b11, 0, 0);
    drive(0, 32'h0,   2'b00, 0, 0);
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst_out_valid", 128'(out_valid), 128'(0));
    check("arst_stall_cnt", 128'(stall_cnt), 128'(0));
    check("arst_in_ready", 128'(in_ready), 128'(1));
    check("arst_out_mask", 128'(out_mask), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Randomized traffic: heavy back-pressure, then mostly free-flowing.
    repeat (400) drive_rand(50);
    apply_reset();
    repeat (400) drive_rand(90);
    repeat (4) drive(0, 32'h0, 2'b00, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
